// File: rtl/regfile_scanner.sv
// Debug read-out master: stalls the core, walks a register range through
// a dedicated read port and streams each word out with valid/ready.
module regfile_scanner #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [A_WIDTH-1:0] first_addr,
  input  logic [A_WIDTH-1:0] last_addr,
  output logic               busy,
  output logic               stall_req,
  input  logic               stall_ack,
  output logic [A_WIDTH-1:0] rf_addr,
  input  logic [D_WIDTH-1:0] rf_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH-1:0] out_addr,
  output logic               out_last,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STALL,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [A_WIDTH-1:0] r_cur;
  logic [A_WIDTH-1:0] r_last;
  logic [A_WIDTH-1:0] r_rf_addr;
  logic [D_WIDTH-1:0] r_out_data;
  logic [A_WIDTH-1:0] r_out_addr;
  logic               r_out_last;
  logic               r_out_valid;
  logic               r_stall_req;
  logic               r_err;

  logic               w_idle;
  logic               w_accept;
  logic               w_reject;
  logic               w_capture;
  logic               w_hs;
  logic               w_at_last;
  logic [A_WIDTH-1:0] w_cur_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle && start && (first_addr <= last_addr);
  assign w_reject  = w_idle && start && (first_addr > last_addr);
  assign w_capture = (r_state == S_READ) && stall_ack;
  assign w_hs      = (r_state == S_SEND) && r_out_valid && out_ready;
  assign w_at_last = (r_cur == r_last);
  assign w_cur_nxt = r_cur + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_STALL;
      S_STALL: if (stall_ack) w_next = S_READ;
      S_READ:  w_next = stall_ack ? S_SEND : S_STALL;
      S_SEND:  if (w_hs) w_next = w_at_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Increment is gated by w_at_last so the top register never wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cur       <= '0;
      r_last      <= '0;
      r_rf_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_stall_req <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_cur       <= first_addr;
        r_last      <= last_addr;
        r_rf_addr   <= first_addr;
        r_stall_req <= 1'b1;
      end
      if (w_capture) begin
        r_out_data  <= rf_data;
        r_out_addr  <= r_cur;
        r_out_last  <= w_at_last;
        r_out_valid <= 1'b1;
      end
      if (w_hs) begin
        r_out_valid <= 1'b0;
        if (!w_at_last) begin
          r_cur     <= w_cur_nxt;
          r_rf_addr <= w_cur_nxt;
        end
      end
      if (r_state == S_DONE) r_stall_req <= 1'b0;
    end
  end

  assign busy      = !w_idle;
  assign stall_req = r_stall_req;
  assign rf_addr   = r_rf_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed bench for regfile_scanner with a behavioural register file.
module tb_regfile_scanner;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy;
  logic          stall_req;
  logic          stall_ack = 1'b1;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          done;
  logic          err;

  logic [DW-1:0] regs [32];
  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  assign rf_data = regs[rf_addr];

  regfile_scanner #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .stall_req(stall_req), .stall_ack(stall_ack),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .done(done), .err(err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int k, input bit lst);
    logic [DW-1:0] d;
    d = k * 32'h0101_0101;
    chk({tag, " valid"}, out_valid, 1'b1);
    chk({tag, " addr"}, out_addr, k);
    chk({tag, " data"}, out_data, d);
    chk({tag, " last"}, out_last, lst);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " stall_req"}, stall_req, 1'b0);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " done"}, done, 1'b0);
  endtask

  task automatic go(input int f, input int l);
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h0101_0101;

    // reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst rf_addr", rf_addr, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst out_last", out_last, 0);
    chk("rst err", err, 0);
    RST = 1'b0;
    tick();

    // full scan 0..31, two cycles per word
    go(0, 31);
    chk("t1 c1 busy", busy, 1);
    chk("t1 c1 stall_req", stall_req, 1);
    chk("t1 c1 rf_addr", rf_addr, 0);
    chk("t1 c1 valid", out_valid, 0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("t1 gap valid", out_valid, 0);
      chk("t1 rf_addr", rf_addr, k);
      tick();
      chk_beat("t1 beat", k, k == 31);
    end
    tick();
    chk("t1 done", done, 1);
    chk("t1 done stall_req", stall_req, 1);
    chk("t1 done valid", out_valid, 0);
    tick();
    chk_idle("t1 end");

    // back-pressure: scan 10..12, ready low 5 cycles per beat
    out_ready = 1'b0;
    go(10, 12);
    tick();
    for (int k = 10; k <= 12; k++) begin
      tick();
      chk_beat("t2 beat", k, k == 12);
      for (int j = 0; j < 5; j++) begin
        tick();
        chk_beat("t2 hold", k, k == 12);
      end
      out_ready = 1'b1;
      tick();
      chk("t2 post valid", out_valid, 0);
      out_ready = 1'b0;
    end
    chk("t2 done", done, 1);
    tick();
    chk_idle("t2 end");
    out_ready = 1'b1;

    // rejected start
    go(20, 4);
    chk("t3 err", err, 1);
    chk_idle("t3");
    tick();
    chk("t3 err drop", err, 0);
    chk_idle("t3 after");

    // stall_ack late, then dropped in READ
    stall_ack = 1'b0;
    go(5, 6);
    for (int j = 0; j < 7; j++) begin
      chk("t4 wait valid", out_valid, 0);
      chk("t4 wait stall_req", stall_req, 1);
      tick();
    end
    stall_ack = 1'b1;
    tick();
    chk("t4 read rf_addr", rf_addr, 5);
    stall_ack = 1'b0;
    tick();
    chk("t4 drop1 valid", out_valid, 0);
    tick();
    chk("t4 drop2 valid", out_valid, 0);
    stall_ack = 1'b1;
    tick();
    chk("t4 reread valid", out_valid, 0);
    tick();
    chk_beat("t4 beat", 5, 0);
    tick();
    tick();
    chk_beat("t4 beat", 6, 1);
    tick();
    chk("t4 done", done, 1);
    tick();
    chk_idle("t4 end");

    // single register at the top of the range
    go(31, 31);
    chk("t5 rf_addr", rf_addr, 31);
    tick();
    tick();
    chk_beat("t5 beat", 31, 1);
    tick();
    chk("t5 done", done, 1);
    tick();
    chk_idle("t5 end");

    // reset mid-scan while SEND at addr 7
    go(0, 31);
    for (int k = 0; k < 8; k++) begin
      tick();
      tick();
    end
    chk_beat("t6 pre", 7, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_idle("t6 rst");
    chk("t6 rf_addr", rf_addr, 0);
    chk("t6 out_data", out_data, 0);
    chk("t6 out_addr", out_addr, 0);
    chk("t6 out_last", out_last, 0);
    tick();
    chk_idle("t6 rst2");

    // clean scan 2..4 with an ignored start and address changes
    go(2, 4);
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_beat("t6 beat", 2, 0);
    for (int k = 3; k <= 4; k++) begin
      tick();
      tick();
      chk_beat("t6 beat", k, k == 4);
    end
    tick();
    chk("t6 done", done, 1);
    tick();
    chk_idle("t6 end");
    tick();
    tick();
    chk_idle("t6 quiet");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
